branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  synchronous reset, active-low; sampled only on the clk_i rising edge.
REQ-004 stall_in  in  1  load-use stall: ID holds its instruction, EX receives a bubble.
REQ-005 id_branch_in  in  1  branch instruction present in ID, requesting a prediction.
REQ-006 predict_taken_out  out  1  prediction for the ID branch: 1 = fetch target, 0 = fetch PC+4.
REQ-007 ex_branch_in  in  1  branch instruction resolving in EX.
REQ-008 ex_taken_in  in  1  actual outcome from the branch-decision stage: 1 = taken.
REQ-009 flush_out  out  1  misprediction: squash IF/ID and redirect the PC.
REQ-010 redirect_taken_out  out  1  correct path when flush_out = 1: 1 = branch target, 0 = branch PC+4.
REQ-011 state_out  out  2  current counter state, for debug.
REQ-012 branch_cnt_out  out  16  resolved-branch count (see Configuration).
REQ-013 miss_cnt_out  out  16  misprediction count (see Configuration).

Function
REQ-014 Core SHALL be a 2-bit saturating counter, state encoding SNT=00, WNT=01, WT=10, ST=11.
REQ-015 predict_taken_out SHALL be combinational: id_branch_in AND state[1], taken from the registered state before any same-cycle update.
REQ-016 Pending record: pend_valid and pend_pred (1 bit each) SHALL track the prediction of the branch that occupies EX in the following cycle.
REQ-017 Each edge the pending record SHALL update with the first matching rule:
  - flush_out = 1 or stall_in = 1: pend_valid <= 0.
  - id_branch_in = 1: pend_valid <= 1; pend_pred <= predict_taken_out.
  - otherwise: pend_valid <= 0.
REQ-018 A resolve event is ex_branch_in = 1 AND pend_valid = 1.
REQ-019 ex_branch_in = 1 with pend_valid = 0 SHALL be ignored: no counter update, no flush.
REQ-020 On a resolve event the counter SHALL move one step toward ST if ex_taken_in = 1, and one step toward SNT otherwise.
REQ-021 At ST the counter SHALL stay at ST on a taken outcome; at SNT it SHALL stay at SNT on a not-taken outcome; it SHALL never wrap.
REQ-022 flush_out SHALL be combinational, asserted in the same cycle: resolve event AND (pend_pred != ex_taken_in).
REQ-023 redirect_taken_out SHALL equal ex_taken_in when flush_out = 1, and SHALL be 0 otherwise.
REQ-024 Same-cycle resolve and ID prediction: ID SHALL use the pre-update state, and the counter update SHALL take effect at the edge.
REQ-025 Same-cycle flush and ID branch: the ID branch is wrong-path, so no pending record SHALL be created (REQ-017).
REQ-026 Latency: one cycle from a state update to the new state being visible on predict_taken_out and state_out.

Reset
REQ-027 With rst_i = 0 at a rising edge, the next state SHALL be: state = ST (11), pend_valid = 0, pend_pred = 0, both counters = 0.
REQ-028 During and after reset, outputs SHALL be: flush_out = 0 and redirect_taken_out = 0, since pend_valid = 0; predict_taken_out = id_branch_in.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight pending record; no flush SHALL be issued for that record.

Configuration
REQ-030 Macro BRANCH_PREDICTOR_STATS_EN SHALL compile the statistics counters in or out.
  - Defined: branch_cnt_out SHALL increment on every resolve event.
  - Defined: miss_cnt_out SHALL increment on every flush_out = 1 cycle.
  - Defined: both counters SHALL saturate at 16'hFFFF and never wrap.
  - Undefined: both ports SHALL remain present, tied to 16'h0000, with no counter flops.

Verification
REQ-031 Reset, then ID branch, then T in EX: predict 1 -> flush_out = 0; state stays 11.
REQ-032 From ST, resolve N: flush_out = 1, redirect_taken_out = 0, state 10; resolve N again: flush_out = 1, redirect_taken_out = 0, state 01; third ID branch predicts 0.
REQ-033 From SNT, resolve N x3: state stays 00, flush_out = 0 each time; then resolve T: flush_out = 1, redirect_taken_out = 1, state 01.
REQ-034 ID branch with stall_in = 1 for 2 cycles, then released: EX branches during the stall are ignored; the branch resolves 1 cycle after release using the prediction from the release cycle.
REQ-035 Mispredict flush with id_branch_in = 1 in the same cycle: the next-cycle ex_branch_in = 1 causes no update and no flush.
REQ-036 With BRANCH_PREDICTOR_STATS_EN defined, 5 resolves including 2 mispredicts give branch_cnt_out = 5 and miss_cnt_out = 2; preloaded at 16'hFFFF, they stay at FFFF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Pipeline-side signal bundle for branch_predictor: ID prediction request, EX resolution and flush/debug outputs.
// master = pipeline driving requests, slave = predictor.
interface branch_predictor_if;
  logic        stall_in;
  logic        id_branch_in;
  logic        predict_taken_out;
  logic        ex_branch_in;
  logic        ex_taken_in;
  logic        flush_out;
  logic        redirect_taken_out;
  logic [1:0]  state_out;
  logic [15:0] branch_cnt_out;
  logic [15:0] miss_cnt_out;

  modport master (
    output stall_in, id_branch_in, ex_branch_in, ex_taken_in,
    input  predict_taken_out, flush_out, redirect_taken_out,
    input  state_out, branch_cnt_out, miss_cnt_out
  );

  modport slave (
    input  stall_in, id_branch_in, ex_branch_in, ex_taken_in,
    output predict_taken_out, flush_out, redirect_taken_out,
    output state_out, branch_cnt_out, miss_cnt_out
  );
endinterface

// File: rtl/branch_predictor.sv
// Single 2-bit saturating-counter branch predictor with a one-entry pending record tracking the branch in EX.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor (
  input  logic                 clk_i,
  input  logic                 rst_i,
  branch_predictor_if.slave    bp
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  ctr_e state_q, state_d;
  logic pend_valid_q, pend_valid_d;
  logic pend_pred_q, pend_pred_d;

  logic predict_taken;
  logic resolve;
  logic flush;

  // Resolve is masked while reset is held so an in-flight record can never flush.
  always_comb begin
    predict_taken = bp.id_branch_in & state_q[1];
    resolve       = bp.ex_branch_in & pend_valid_q & rst_i;
    flush         = resolve & (pend_pred_q != bp.ex_taken_in);
  end

  always_comb begin
    state_d = state_q;
    if (resolve) begin
      if (bp.ex_taken_in) begin
        unique case (state_q)
          SNT:     state_d = WNT;
          WNT:     state_d = WT;
          WT:      state_d = ST;
          default: state_d = ST;
        endcase
      end else begin
        unique case (state_q)
          ST:      state_d = WT;
          WT:      state_d = WNT;
          WNT:     state_d = SNT;
          default: state_d = SNT;
        endcase
      end
    end
  end

  // A branch in ID during a flush is wrong-path; during a stall EX gets a bubble.
  always_comb begin
    pend_valid_d = 1'b0;
    pend_pred_d  = pend_pred_q;
    if (flush || bp.stall_in) begin
      pend_valid_d = 1'b0;
    end else if (bp.id_branch_in) begin
      pend_valid_d = 1'b1;
      pend_pred_d  = predict_taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST;
      pend_valid_q <= 1'b0;
      pend_pred_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pred_q  <= pend_pred_d;
    end
  end

  assign bp.predict_taken_out  = predict_taken;
  assign bp.flush_out          = flush;
  assign bp.redirect_taken_out = flush & bp.ex_taken_in;
  assign bp.state_out          = state_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve && (branch_cnt_q != 16'hFFFF)) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end
    if (flush && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branch_cnt_q <= 16'h0000;
      miss_cnt_q   <= 16'h0000;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bp.branch_cnt_out = branch_cnt_q;
  assign bp.miss_cnt_out   = miss_cnt_q;
`else
  assign bp.branch_cnt_out = 16'h0000;
  assign bp.miss_cnt_out   = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios followed by random pipeline traffic,
// checked against an integer-level model of the saturating counter and pending branch.
module tb_branch_predictor;

  logic clk_i;
  logic rst_i;
  branch_predictor_if bp ();

  branch_predictor dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bp    (bp.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Expected record: predict, flush, redirect, state[1:0], branch_cnt[15:0], miss_cnt[15:0]
  logic [36:0] exp_q[$];
  int checks;
  int errors;

  // Reference model
  int m_ctr;
  bit m_pv;
  bit m_pp;
  int m_bc;
  int m_mc;
  bit m_known;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [36:0] e;
      e = exp_q.pop_front();
      check("predict_taken", {15'd0, bp.predict_taken_out}, {15'd0, e[36]});
      check("flush", {15'd0, bp.flush_out}, {15'd0, e[35]});
      check("redirect_taken", {15'd0, bp.redirect_taken_out}, {15'd0, e[34]});
      check("state", {14'd0, bp.state_out}, {14'd0, e[33:32]});
      check("branch_cnt", bp.branch_cnt_out, e[31:16]);
      check("miss_cnt", bp.miss_cnt_out, e[15:0]);
    end
  end

  task automatic drive(input bit rst, input bit stall, input bit idb, input bit exb, input bit ext);
    bit pred, resolve, flush, redir;
    logic [15:0] bc, mc;
    @(posedge clk_i);
    #1;
    rst_i           = rst;
    bp.stall_in     = stall;
    bp.id_branch_in = idb;
    bp.ex_branch_in = exb;
    bp.ex_taken_in  = ext;
    pred    = idb && (m_ctr >= 2);
    resolve = rst && exb && m_pv;
    flush   = resolve && (m_pp != ext);
    redir   = flush && ext;
`ifdef BRANCH_PREDICTOR_STATS_EN
    bc = 16'(m_bc);
    mc = 16'(m_mc);
`else
    bc = 16'h0000;
    mc = 16'h0000;
`endif
    if (m_known) exp_q.push_back({pred, flush, redir, 2'(m_ctr), bc, mc});
    // Model advance to the state after the coming edge
    if (!rst) begin
      m_ctr = 3; m_pv = 0; m_pp = 0; m_bc = 0; m_mc = 0; m_known = 1;
    end else begin
      if (resolve) begin
        m_ctr = ext ? ((m_ctr == 3) ? 3 : m_ctr + 1) : ((m_ctr == 0) ? 0 : m_ctr - 1);
        if (m_bc < 65535) m_bc++;
      end
      if (flush && m_mc < 65535) m_mc++;
      if (flush || stall) m_pv = 0;
      else if (idb) begin m_pv = 1; m_pp = pred; end
      else m_pv = 0;
    end
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic branch(input bit taken);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, taken);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_ctr = 3; m_pv = 0; m_pp = 0; m_bc = 0; m_mc = 0; m_known = 0;
    rst_i = 1'b0;
    bp.stall_in = 0; bp.id_branch_in = 0; bp.ex_branch_in = 0; bp.ex_taken_in = 0;

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    idle();

    // Taken from ST: correct prediction, state holds
    branch(1);
    // Two not-taken from ST, then a third prediction should be not-taken
    branch(0);
    branch(0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    // Drive to SNT and saturate there, then one taken flips toward WNT
    branch(0); branch(0); branch(0); branch(0);
    branch(1);
    idle();

    // Stall: ID branch held two cycles with EX branches ignored, then released
    drive(1, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1);
    idle();

    // Mispredict flush with a same-cycle ID branch: next EX branch is ignored
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, (m_ctr < 2));
    drive(1, 0, 0, 1, 1);
    idle();

    // Reset while a mispredicting branch sits in EX
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, (m_ctr < 2));
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) == 1));
    end
    idle();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
